// File: rtl/uart_fft_pkg.sv
// Shared definitions for the UART-to-FFT sample path: state encodings, sample width
// and the default frame sync marker.
package uart_fft_pkg;

    localparam int unsigned SAMPLE_W = 16;
    localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;

    localparam logic [2:0] S_SYNC = 3'd0;
    localparam logic [2:0] S_LO   = 3'd1;
    localparam logic [2:0] S_HI   = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_CSUM = 3'd4;

    typedef enum logic [2:0] {
        ST_SYNC = S_SYNC,
        ST_LO   = S_LO,
        ST_HI   = S_HI,
`ifdef FRAME_CHECKSUM_EN
        ST_CSUM = S_CSUM,
`endif
        ST_WAIT = S_WAIT
    } asm_state_e;

endpackage

// File: rtl/uart_byte_timeout.sv
// Loadable down-counter: restarts from i_load_val on i_clr, counts while i_en and
// pulses o_expire (combinationally) on the enabled cycle it sits at zero.
module uart_byte_timeout #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_clr,
    input  logic             i_en,
    output logic             o_expire
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (i_clr) begin
            count_d = i_load_val;
        end else if (i_en && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    assign o_expire = i_en && !i_clr && (count_q == '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_frame_assembler.sv
// Hunts for a sync byte, packs little-endian byte pairs into 16-bit samples for the FFT
// sample RAM and holds each full frame until acked. FRAME_CHECKSUM_EN adds a sum byte.
module uart_frame_assembler
    import uart_fft_pkg::*;
#(
    parameter int unsigned FRAME_LEN     = 256,
    parameter int unsigned ADDR_WIDTH    = 8,
    parameter logic [7:0]  SYNC_BYTE     = SYNC_BYTE_DEFAULT,
    parameter int unsigned TIMEOUT_TICKS = 2816
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_rx_flag,
    input  logic [7:0]            i_rx_byte,
    output logic                  o_wr_en,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [SAMPLE_W-1:0]   o_wr_data,
    output logic                  o_frame_ready,
    input  logic                  i_frame_ack,
    output logic                  o_overrun,
`ifdef FRAME_CHECKSUM_EN
    output logic                  o_timeout,
    output logic                  o_csum_err
`else
    output logic                  o_timeout
`endif
);

    localparam logic [ADDR_WIDTH-1:0] LastIdx = ADDR_WIDTH'(FRAME_LEN - 1);
    localparam logic [15:0]           ToLoad  = 16'(TIMEOUT_TICKS - 1);

    asm_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] index_q, index_d;
    logic [7:0]            lo_q, lo_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [SAMPLE_W-1:0]   wr_data_q, wr_data_d;
    logic                  ready_q, ready_d;
    logic                  overrun_q, overrun_d;
    logic                  timeout_q, timeout_d;
`ifdef FRAME_CHECKSUM_EN
    logic [7:0]            sum_q, sum_d;
    logic                  csum_err_q, csum_err_d;
`endif

    logic byte_v;
    logic running;
    logic expire;

    assign byte_v = ~i_rx_flag;

`ifdef FRAME_CHECKSUM_EN
    assign running = (state_q == ST_LO) || (state_q == ST_HI) || (state_q == ST_CSUM);
`else
    assign running = (state_q == ST_LO) || (state_q == ST_HI);
`endif

    // Idle states hold the counter in reload so every in-frame stretch starts fresh.
    uart_byte_timeout #(
        .WIDTH (16)
    ) u_timeout (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load_val (ToLoad),
        .i_clr      (byte_v || !running),
        .i_en       (running),
        .o_expire   (expire)
    );

    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        lo_d      = lo_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        overrun_d = overrun_q;
        timeout_d = 1'b0;
`ifdef FRAME_CHECKSUM_EN
        sum_d      = sum_q;
        csum_err_d = 1'b0;
`endif
        unique case (state_q)
            ST_SYNC: begin
                if (byte_v && (i_rx_byte == SYNC_BYTE)) begin
                    state_d = ST_LO;
                    index_d = '0;
`ifdef FRAME_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            ST_LO: begin
                if (byte_v) begin
                    lo_d    = i_rx_byte;
                    state_d = ST_HI;
`ifdef FRAME_CHECKSUM_EN
                    sum_d   = sum_q + i_rx_byte;
`endif
                end
            end
            ST_HI: begin
                if (byte_v) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = index_q;
                    wr_data_d = {i_rx_byte, lo_q};
`ifdef FRAME_CHECKSUM_EN
                    sum_d     = sum_q + i_rx_byte;
`endif
                    if (index_q == LastIdx) begin
                        index_d = '0;
`ifdef FRAME_CHECKSUM_EN
                        state_d = ST_CSUM;
`else
                        state_d = ST_WAIT;
`endif
                    end else begin
                        index_d = index_q + ADDR_WIDTH'(1);
                        state_d = ST_LO;
                    end
                end
            end
`ifdef FRAME_CHECKSUM_EN
            ST_CSUM: begin
                if (byte_v) begin
                    if (i_rx_byte == sum_q) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d    = ST_SYNC;
                        csum_err_d = 1'b1;
                    end
                end
            end
`endif
            ST_WAIT: begin
                // A byte arriving with the ack is still lost, so it still flags overrun.
                if (byte_v) begin
                    overrun_d = 1'b1;
                end
                if (i_frame_ack) begin
                    state_d = ST_SYNC;
                end
            end
            default: state_d = ST_SYNC;
        endcase

        if (expire) begin
            state_d   = ST_SYNC;
            index_d   = '0;
            timeout_d = 1'b1;
        end

        ready_d = (state_d == ST_WAIT);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_SYNC;
            index_q   <= '0;
            lo_q      <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            ready_q   <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
            sum_q      <= '0;
            csum_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            lo_q      <= lo_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            ready_q   <= ready_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
`ifdef FRAME_CHECKSUM_EN
            sum_q      <= sum_d;
            csum_err_q <= csum_err_d;
`endif
        end
    end

    assign o_wr_en       = wr_en_q;
    assign o_wr_addr     = wr_addr_q;
    assign o_wr_data     = wr_data_q;
    assign o_frame_ready = ready_q;
    assign o_overrun     = overrun_q;
    assign o_timeout     = timeout_q;
`ifdef FRAME_CHECKSUM_EN
    assign o_csum_err    = csum_err_q;
`endif

endmodule

// File: doc/uart_frame_assembler.md
Name: uart_frame_assembler

Overview:
- Sits directly downstream of the UART receiver and upstream of the FFT sample RAM.
- Consumes received bytes, hunts for a sync byte, and packs byte pairs little-endian into signed 16-bit samples.
- Writes each sample into the sample RAM and raises frame-ready once FRAME_LEN samples are stored.
- Holds the frame until the FFT core acknowledges it; an inter-byte timeout resynchronises on a broken stream.

Parameters:
- FRAME_LEN, 256, samples per frame; power of two, 2..4096.
- ADDR_WIDTH, 8, sample RAM address width; must equal log2(FRAME_LEN).
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_TICKS, 2816, clocks without a byte before an in-frame abort (22 bit times at 128 ticks/bit); width 16.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous, active-high reset.
- i_rx_flag  in  1  receiver strobe, active-low: low for exactly one cycle when i_rx_byte is valid; idles high.
- i_rx_byte  in  8  received byte; sampled only while i_rx_flag is 0.
- o_wr_en  out  1  sample RAM write strobe, one cycle.
- o_wr_addr  out  ADDR_WIDTH  sample index.
- o_wr_data  out  16  sample, {hi_byte, lo_byte}.
- o_frame_ready  out  1  level; a full frame is in RAM.
- i_frame_ack  in  1  one-cycle pulse from the FFT core releasing the frame.
- o_overrun  out  1  sticky: a byte was dropped while waiting for ack.
- o_timeout  out  1  one-cycle pulse on an in-frame timeout abort.

Behaviour:
- Byte event: byte_v = (i_rx_flag == 0). Every FSM action below is taken only on byte_v, except timeout and ack handling.
- Reset: state S_SYNC, sample index 0, lo-byte register 0, timeout counter 0; all outputs 0.
- S_SYNC:
  - byte equal to SYNC_BYTE -> S_LO with index 0.
  - any other byte -> ignored.
- S_LO: byte is latched as the low byte -> S_HI.
- S_HI:
  - Registered write, visible the cycle after byte_v: o_wr_en=1, o_wr_addr=index, o_wr_data={byte, lo}.
  - index < FRAME_LEN-1 -> index+1, S_LO.
  - index == FRAME_LEN-1 -> index wraps to 0, S_WAIT.
- S_WAIT:
  - o_frame_ready=1, asserted the same cycle as the final o_wr_en.
  - Incoming bytes are discarded and set o_overrun.
  - i_frame_ack -> o_frame_ready=0 next cycle, S_SYNC.
  - Ack and byte_v in the same cycle: ack wins and the byte is dropped; overrun is still set.
- Timeout counter:
  - Runs only in S_LO and S_HI; clears on every byte_v and on entry to those states.
  - Reaching TIMEOUT_TICKS-1 -> S_SYNC, index 0, one-cycle o_timeout pulse.
  - Samples already written stay in RAM and are overwritten by the next frame.
- i_frame_ack outside S_WAIT: ignored.
- o_overrun clears only on i_rst.
- Reset mid-frame: immediate return to S_SYNC; o_frame_ready drops.
- A data byte equal to SYNC_BYTE inside a frame is treated as data, not resync.

Optional Feature:
- Macro FRAME_CHECKSUM_EN.
- When defined:
  - After the last HI byte the FSM enters S_CSUM instead of S_WAIT.
  - The next byte is compared with the 8-bit modulo-256 sum of all 2*FRAME_LEN data bytes; the sum excludes SYNC_BYTE and is cleared on sync.
  - Match -> S_WAIT with o_frame_ready set the cycle after the checksum byte.
  - Mismatch -> S_SYNC plus a one-cycle o_csum_err output pulse.
  - The timeout counter also runs in S_CSUM.
- When undefined: no S_CSUM state, no sum register, no o_csum_err port.

Decomposition:
- Shared package uart_fft_pkg holds:
  - state encodings S_SYNC, S_LO, S_HI, S_WAIT, S_CSUM as 3-bit localparams;
  - SAMPLE_W=16;
  - default SYNC_BYTE.
- One sub-module is natural: uart_byte_timeout, a loadable down-counter with clear, enable and expiry pulse, reusable by a future TX path.
- Packing logic stays inline.

Test Plan:
- Sync then data:
  - Stimulus: reset, then A5, 34, 12, 78, 56 with FRAME_LEN=4 in the bench.
  - Required: writes (addr0, 16'h1234) and (addr1, 16'h5678), each one cycle after its hi byte.
- Full frame:
  - Stimulus: A5 followed by 8 bytes, FRAME_LEN=4.
  - Required: 4 writes at addresses 0..3, o_frame_ready=1 on the 4th write cycle, then i_frame_ack pulse.
  - Required: ready low next cycle, state S_SYNC.
- Garbage before sync:
  - Stimulus: 00, FF, 5A, then A5, 01, 00.
  - Required: exactly one write, data 16'h0001 at addr 0.
- Overrun:
  - Stimulus: full frame, then byte 0x11 before ack.
  - Required: no write, o_overrun=1 and it stays 1 after ack.
- Timeout:
  - Stimulus: A5, 34, then 2816 idle cycles.
  - Required: o_timeout pulses once, no write.
  - Follow-up: A5, CD, AB gives a write of 16'hABCD at addr 0.
- Checksum (FRAME_CHECKSUM_EN, FRAME_LEN=2):
  - Stimulus: A5, 01, 02, 03, 04, 0A.
  - Required: frame ready.
  - Stimulus: same frame with final byte 0B.
  - Required: o_csum_err pulse, ready stays 0.
